// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_arb_pkg;

  localparam int LED_W = 8;
  localparam logic [LED_W-1:0] DEFAULT_IDLE_PATTERN = 8'h01;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/led_arb_rr_pick.sv
// Combinational round-robin find-first: scans req starting at ptr, wrapping
// modulo NUM_REQ, and reports the first asserted requester.
module led_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               pick_valid
);

  int cand;

  // Scan from the farthest offset back to the nearest so the closest hit wins.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    cand        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand]) begin
        pick_onehot       = '0;
        pick_onehot[cand] = 1'b1;
        pick_idx          = PTR_W'(cand);
        pick_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the 8-bit LED bank with bounded hold time.
// Optional LED[0] heartbeat enabled by defining LED_ARB_HEARTBEAT_EN.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int               NUM_REQ       = 4,
  parameter int               MAX_HOLD      = 50_000_000,
  parameter logic [LED_W-1:0] IDLE_PATTERN  = DEFAULT_IDLE_PATTERN,
  parameter int               HEARTBEAT_DIV = 25_000_000
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_led,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         LED
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          state_reg, state_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [PTR_W-1:0]    owner_reg, owner_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic [LED_W-1:0]    led_reg, led_next;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                owner_release;
  logic                owner_preempt;

  logic [LED_W-1:0]    led_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign led_slice[gi] = req_led[gi*LED_W +: LED_W];
    end
  endgenerate

  led_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req         (req),
    .ptr         (ptr_reg),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  assign owner_release = !req[owner_reg];
  assign owner_preempt = (MAX_HOLD != 0) && (hold_reg == HOLD_LAST)
                         && (|(req & ~grant_reg));

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    hold_next  = hold_reg;
    led_next   = IDLE_PATTERN;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          grant_next = pick_onehot;
          owner_next = pick_idx;
          hold_next  = '0;
        end
      end
      GRANT: begin
        led_next  = led_slice[owner_reg];
        hold_next = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + 1'b1;
        // Release and preemption end the grant identically.
        if (owner_release || owner_preempt) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
      owner_reg <= '0;
      hold_reg  <= '0;
      led_reg   <= IDLE_PATTERN;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      hold_reg  <= hold_next;
      led_reg   <= led_next;
    end
  end

  assign grant = grant_reg;

`ifdef LED_ARB_HEARTBEAT_EN
  localparam int HB_W = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_DIV - 1);

  logic [HB_W-1:0] hb_cnt_reg;
  logic            hb_reg;

  // Free-running, independent of arbitration; replaces LED[0].
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hb_cnt_reg <= '0;
      hb_reg     <= 1'b1;
    end else if (hb_cnt_reg == HB_LAST) begin
      hb_cnt_reg <= '0;
      hb_reg     <= ~hb_reg;
    end else begin
      hb_cnt_reg <= hb_cnt_reg + 1'b1;
    end
  end

  assign LED = {led_reg[LED_W-1:1], hb_reg};
`else
  assign LED = led_reg;
`endif

endmodule
